// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data RAM between the CPU load/store port and a debug/loader port.
// The CPU has default priority, a saturating wait counter bounds debug latency, and halt locks the RAM to debug.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,

  input  logic              dbg_halt,
  output logic              cpu_halted,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_full;
  logic             cpu_gnt_raw;
  logic             dbg_gnt_raw;
  logic             rd_cpu;
  logic             rd_dbg;

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      NORMAL: if (dbg_halt)  state_next = LOCKED;
      LOCKED: if (!dbg_halt) state_next = NORMAL;
      default:               state_next = NORMAL;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cpu_halted = 1'b0;
    if (state == LOCKED) begin
      cpu_halted = 1'b1;
    end
  end

  assign wait_full = (wait_cnt >= WAIT_SAT);

  // Priority decision before reset gating; at most one grant can be set
  always_comb begin
    cpu_gnt_raw = 1'b0;
    dbg_gnt_raw = 1'b0;
    if (state == LOCKED) begin
      dbg_gnt_raw = dbg_req;
    end else if (wait_full) begin
      dbg_gnt_raw = dbg_req;
      cpu_gnt_raw = cpu_req & ~dbg_req;
    end else begin
      cpu_gnt_raw = cpu_req;
      dbg_gnt_raw = dbg_req & ~cpu_req;
    end
  end

  // Registered state below is fed from the ungated grants: those flops are held
  // in reset anyway, so only the visible outputs need the reset gate.
  assign cpu_gnt   = cpu_gnt_raw & ~reset;
  assign dbg_gnt   = dbg_gnt_raw & ~reset;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory mux, all-zero when idle
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  // Saturating count of cycles a debug request has been refused
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (dbg_gnt_raw) begin
      wait_cnt <= '0;
    end else if (dbg_req && !wait_full) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Read-owner flags track which port gets the next cycle's mem_rdata
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_cpu <= 1'b0;
      rd_dbg <= 1'b0;
    end else begin
      rd_cpu <= cpu_gnt_raw & ~cpu_we;
      rd_dbg <= dbg_gnt_raw & ~dbg_we;
    end
  end

  assign cpu_rvalid = rd_cpu;
  assign dbg_rvalid = rd_dbg;
  assign cpu_rdata  = rd_cpu ? mem_rdata : '0;
  assign dbg_rdata  = rd_dbg ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read data,
// a negedge monitor pops it whenever an rvalid appears.
module tb_dmem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              CLK = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_stall, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dbg_req, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_halt, cpu_halted;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] cpu_q[$];
  logic [DATA_W-1:0] dbg_q[$];
  logic [DATA_W-1:0] ram[256];

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .cpu_halted(cpu_halted),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port RAM with registered read data
  always @(posedge CLK) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares on every rvalid
  always @(negedge CLK) begin
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL cpu_rvalid_unexpected: got rvalid=1 data=%0h, expected no read at %0t", cpu_rdata, $time);
      end else begin
        chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
      end
    end
    if (dbg_rvalid) begin
      if (dbg_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL dbg_rvalid_unexpected: got rvalid=1 data=%0h, expected no read at %0t", dbg_rdata, $time);
      end else begin
        chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  // Advance to posedge+1 for driving; callers then wait #3 before checking
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h10] = 8'hA5;
    ram[8'h11] = 8'h5A;
    ram[8'h12] = 8'hC3;
    ram[8'h13] = 8'h77;
    mem_rdata = '0;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_halt = 1'b0;

    // Outputs while reset is held
    #3;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_cpu_stall", cpu_stall, 1);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_cpu_halted", cpu_halted, 0);
    chk("rst_rvalid", {cpu_rvalid, dbg_rvalid}, 0);
    chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
    #7;
    reset = 1'b0;
    cpu_req = 1'b0;

    // Single CPU load of 0x10
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    #3;
    chk("t1_cpu_gnt", cpu_gnt, 1);
    chk("t1_cpu_stall", cpu_stall, 0);
    chk("t1_dbg_gnt", dbg_gnt, 0);
    chk("t1_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 8'h10});
    cpu_q.push_back(8'hA5);
    step();
    cpu_req = 1'b0;
    #3;
    chk("t1_dbg_idle", {dbg_gnt, dbg_rvalid, dbg_rdata}, 0);
    chk("t1_mem_idle", mem_en, 0);

    // Continuous contention: 4 CPU grants then 1 debug grant, repeating
    for (int k = 0; k < 10; k++) begin
      logic exp_dbg;
      step();
      cpu_req = 1'b1; cpu_addr = 8'h11; cpu_we = 1'b0;
      dbg_req = 1'b1; dbg_addr = 8'h12; dbg_we = 1'b0;
      exp_dbg = ((k % 5) == 4);
      #3;
      chk("t2_cpu_gnt", cpu_gnt, !exp_dbg);
      chk("t2_dbg_gnt", dbg_gnt, exp_dbg);
      chk("t2_cpu_stall", cpu_stall, exp_dbg);
      chk("t2_mem_addr", mem_addr, exp_dbg ? 8'h12 : 8'h11);
      if (exp_dbg) dbg_q.push_back(8'hC3);
      else         cpu_q.push_back(8'h5A);
    end
    step();
    cpu_req = 1'b0; dbg_req = 1'b0;

    // Halt raised with a pending CPU load: CPU still granted this cycle
    step();
    dbg_halt = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h13;
    #3;
    chk("t3_cpu_gnt_last_normal", cpu_gnt, 1);
    chk("t3_halted_pre", cpu_halted, 0);
    cpu_q.push_back(8'h77);
    step();
    #3;
    chk("t3_halted", cpu_halted, 1);
    chk("t3_cpu_gnt_locked", cpu_gnt, 0);
    chk("t3_cpu_stall", cpu_stall, 1);
    chk("t3_mem_en_idle", mem_en, 0);
    step();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h3C;
    #3;
    chk("t3_dbg_store_gnt", dbg_gnt, 1);
    chk("t3_store_bus", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 8'h20, 8'h3C});
    chk("t3_cpu_stall_st", cpu_stall, 1);
    step();
    dbg_we = 1'b0; dbg_wdata = '0;
    #3;
    chk("t3_dbg_load_gnt", dbg_gnt, 1);
    chk("t3_load_bus", {mem_we, mem_addr}, {1'b0, 8'h20});
    chk("t3_cpu_gnt_ld", cpu_gnt, 0);
    dbg_q.push_back(8'h3C);
    step();
    dbg_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t3_locked_hold", {cpu_gnt, cpu_stall, mem_en}, {1'b0, 1'b1, 1'b0});
      step();
    end
    dbg_halt = 1'b0;
    #3;
    chk("t3_unhalt_still_locked", cpu_gnt, 0);
    step();
    #3;
    chk("t3_normal_cpu_gnt", cpu_gnt, 1);
    chk("t3_normal_halted", cpu_halted, 0);
    cpu_q.push_back(8'h77);
    step();
    cpu_req = 1'b0;

    // Debug load granted, then reset before its data returns
    step();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h12;
    cpu_req = 1'b1; cpu_addr = 8'h11;
    #3;
    chk("t5_cpu_first", cpu_gnt, 1);
    step();
    cpu_req = 1'b0;
    #3;
    chk("t5_dbg_gnt", dbg_gnt, 1);
    reset = 1'b1;
    step();
    #3;
    chk("t5_rst_outputs", {cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_halted, mem_en}, 0);
    chk("t5_rst_rdata", {cpu_rdata, dbg_rdata}, 0);
    chk("t5_rst_stall", cpu_stall, 0);
    reset = 1'b0;
    dbg_req = 1'b0;
    step();
    #3;
    chk("t5_post_rst", {dbg_rvalid, cpu_halted, mem_en}, 0);

    // Idle: no memory traffic
    for (int k = 0; k < 10; k++) begin
      step();
      #3;
      chk("t6_idle_mem_en", mem_en, 0);
    end

    // Counter held at zero through idle: CPU wins four cycles before debug
    for (int k = 0; k < 5; k++) begin
      logic exp_dbg;
      step();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h31; dbg_wdata = 8'h22;
      exp_dbg = (k == 4);
      #3;
      chk("t6_dbg_gnt", dbg_gnt, exp_dbg);
      chk("t6_mem_wdata", mem_wdata, exp_dbg ? 8'h22 : 8'h11);
    end
    step();
    cpu_req = 1'b0; dbg_req = 1'b0;
    step();
    step();
    #3;
    chk("ram_0x20", ram[8'h20], 8'h3C);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dbg_q_drained", dbg_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port data memory between the CPU load/store port and a debug/loader port.
- Default priority goes to the CPU. A saturating wait counter guarantees the debug port service within MAX_WAIT cycles.
- A halt mode locks the memory to the debug port and stalls the CPU.
- Sits between the single-cycle core's data-memory interface and the data RAM. cpu_stall freezes the core's PC and register writeback.

Parameters:
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- MAX_WAIT, 4, cycles a pending debug request may be denied before it takes priority (≥1).

Ports:
- CLK  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU memory access request; held until granted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; core must hold state.
- cpu_rvalid  out  1  read data valid for the CPU (the cycle after a granted load).
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata  same semantics for the debug port.
- dbg_halt  in  1  request exclusive debug ownership.
- cpu_halted  out  1  high while in LOCKED state.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, registered by memory: valid 1 cycle after mem_en & ~mem_we.

Behaviour:
- FSM states:
  - NORMAL (reset state).
  - LOCKED.
- FSM transitions, evaluated at each CLK edge:
  - NORMAL→LOCKED when dbg_halt = 1.
  - LOCKED→NORMAL when dbg_halt = 0.
  - cpu_halted = (state == LOCKED).
- Grant decision is combinational, within the same cycle:
  - LOCKED: cpu_gnt = 0; dbg_gnt = dbg_req.
  - NORMAL with wait_cnt ≥ MAX_WAIT: dbg_gnt = dbg_req; cpu_gnt = cpu_req & ~dbg_req.
  - NORMAL otherwise: cpu_gnt = cpu_req; dbg_gnt = dbg_req & ~cpu_req.
  - At most one grant is active per cycle.
- Memory mux:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we, mem_addr and mem_wdata come from the granted port.
  - All are 0 when there is no grant.
- wait_cnt:
  - Width is clog2(MAX_WAIT+1); saturates at MAX_WAIT.
  - Increments on cycles where dbg_req & ~dbg_gnt.
  - Clears to 0 on a cycle where dbg_gnt = 1.
  - Holds when dbg_req = 0.
- Read return:
  - Registered owner flags rd_cpu = cpu_gnt & ~cpu_we and rd_dbg = dbg_gnt & ~dbg_we.
  - cpu_rvalid = rd_cpu and dbg_rvalid = dbg_rdata's owner flag rd_dbg, both one cycle after the grant.
  - cpu_rdata = mem_rdata when rd_cpu, else 0. dbg_rdata likewise.
- Writes produce no rvalid.
- Back-to-back grants to either port are allowed every cycle; read latency stays 1.
- Simultaneous events:
  - dbg_halt rising while cpu_req is pending: the CPU may still be granted in that same cycle (NORMAL); from the next cycle it stalls.
  - A CPU load granted in the last NORMAL cycle still returns cpu_rvalid in the first LOCKED cycle.
- Reset (asynchronous, any time):
  - state = NORMAL, wait_cnt = 0, rd_cpu = rd_dbg = 0.
  - While reset = 1, all grants and mem_en are forced to 0.
  - Outputs during reset:
    - 0: cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata, cpu_halted, mem_en, mem_we, mem_addr, mem_wdata.
    - cpu_stall = cpu_req.
  - An in-flight read is dropped; its rvalid never appears.
- Requesters must hold req, we, addr and wdata stable until their grant. The arbiter does not check this.

Test Plan:
- Reset for 10 ns, then CPU loads addr 0x10 (mem holds 0xA5) → cpu_gnt in the same cycle; cpu_rvalid = 1, cpu_rdata = 0xA5 on the next cycle; dbg outputs stay 0.
- cpu_req and dbg_req held continuously, MAX_WAIT = 4 → cpu_gnt for 4 cycles, dbg_gnt on the 5th, wait_cnt back to 0; pattern repeats every 5 cycles; cpu_stall = 1 exactly on dbg-grant cycles.
- dbg_halt = 1 with cpu_req held → cpu_halted = 1 from the next edge. Debug stores 0x3C to addr 0x20, then loads it back → dbg_rdata = 0x3C. cpu_stall = 1 throughout; mem never sees CPU addresses.
- CPU load granted in the same cycle dbg_halt rises → cpu_rvalid pulses the following cycle with the correct data; no further cpu_gnt until dbg_halt = 0.
- Assert reset the cycle after a granted debug load → dbg_rvalid never asserts; all outputs 0 and state NORMAL after reset releases.
- No requests for 10 cycles → mem_en = 0 throughout; wait_cnt stays 0.
